// File: rtl/srlc_pkg.sv
// Shared constants and elaboration helpers for the addressable shift register.
// The optional cascade output is enabled by defining SRLC_CASCADE_EN.
package srlc_pkg;

  localparam int unsigned SRLC_DEPTH_16 = 16;
  localparam int unsigned SRLC_DEPTH_32 = 32;

  // Only the two primitive sizes are modelled.
  function automatic bit srlc_depth_legal(input int unsigned depth);
    return (depth == SRLC_DEPTH_16) || (depth == SRLC_DEPTH_32);
  endfunction

  // Tap address width for a legal depth (4 for 16 stages, 5 for 32).
  function automatic int unsigned srlc_addr_width(input int unsigned depth);
    return (depth == SRLC_DEPTH_32) ? 32'd5 : 32'd4;
  endfunction

endpackage

// File: rtl/srlc_lane.sv
// One single-bit lane: DEPTH-stage shift register with clock enable,
// address-selected combinational tap and (with SRLC_CASCADE_EN) last-stage tap.
module srlc_lane
  import srlc_pkg::*;
#(
  parameter int unsigned      DEPTH = SRLC_DEPTH_16,
  parameter logic [DEPTH-1:0] INIT  = '0,
  localparam int unsigned     AW    = srlc_addr_width(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_ce,
  input  logic [AW-1:0] i_addr,
  input  logic          i_data,
  output logic          o_data
`ifdef SRLC_CASCADE_EN
  ,
  output logic          o_last
`endif
);

  // Bit k holds stage k; stage 0 is the newest sample.
  logic [DEPTH-1:0] stages;

  // Shift on enabled edges; reset reloads INIT immediately and holds it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stages <= INIT;
    end else if (i_ce) begin
      stages <= {stages[DEPTH-2:0], i_data};
    end
  end

  // Tap mux follows the address with no clock involvement.
  always_comb begin
    o_data = stages[i_addr];
  end

`ifdef SRLC_CASCADE_EN
  // Final stage feeds the next instance in a chain.
  always_comb begin
    o_last = stages[DEPTH-1];
  end
`endif

endmodule

// File: rtl/srlc_shift_reg.sv
// Vendor-neutral SRLC16E/SRLC32E-style addressable shift register,
// DATA_WIDTH independent lanes sharing clock, enable, reset and tap address.
// Define SRLC_CASCADE_EN to expose the o_last cascade output.
module srlc_shift_reg
  import srlc_pkg::*;
#(
  parameter int unsigned      DEPTH      = SRLC_DEPTH_16,
  parameter int unsigned      DATA_WIDTH = 8,
  parameter logic [DEPTH-1:0] INIT       = '0,
  localparam int unsigned     AW         = srlc_addr_width(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ce,
  input  logic [AW-1:0]         i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data
`ifdef SRLC_CASCADE_EN
  ,
  output logic [DATA_WIDTH-1:0] o_last
`endif
);

  // Refuse to elaborate depths the primitive does not support.
  if (!srlc_depth_legal(DEPTH)) begin : g_depth_illegal
    $fatal(1, "srlc_shift_reg: DEPTH must be 16 or 32");
  end

  // One independent lane per data bit.
  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_lane
    srlc_lane #(
      .DEPTH (DEPTH),
      .INIT  (INIT)
    ) u_lane (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_ce   (i_ce),
      .i_addr (i_addr),
      .i_data (i_data[g]),
      .o_data (o_data[g])
`ifdef SRLC_CASCADE_EN
      ,
      .o_last (o_last[g])
`endif
    );
  end

endmodule

// File: tb/tb_srlc_shift_reg.sv
// Scoreboard bench for srlc_shift_reg: a 16-stage and a 32-stage instance,
// plus (with SRLC_CASCADE_EN) two chained 32-stage instances giving 64 stages.
module tb_srlc_shift_reg;
  import srlc_pkg::*;

  localparam int unsigned DW     = 8;
  localparam logic [15:0] INIT16 = 16'h8001;
  localparam logic [31:0] INIT32 = 32'hC3A5_0F69;

  typedef struct packed {
    logic [DW-1:0] d16;
    logic [DW-1:0] d32;
`ifdef SRLC_CASCADE_EN
    logic [DW-1:0] l16;
    logic [DW-1:0] l32;
    logic [DW-1:0] c0;
    logic [DW-1:0] c64;
`endif
  } exp_t;

  logic          clk;
  logic          rst;
  logic          ce;
  logic [3:0]    addr16;
  logic [4:0]    addr32;
  logic [DW-1:0] data;
  logic [DW-1:0] o16;
  logic [DW-1:0] o32;
`ifdef SRLC_CASCADE_EN
  logic [DW-1:0] last16;
  logic [DW-1:0] last32;
  logic [DW-1:0] c0_data;
  logic [DW-1:0] c0_last;
  logic [DW-1:0] c1_data;
  logic [DW-1:0] c1_last;
  logic [4:0]    addr_c1;
`endif

  int   n_cmp;
  int   n_bad;
  exp_t exp_q[$];
  // Words written since the last reset, newest first (trimmed to 64).
  logic [DW-1:0] wr_q[$];

  srlc_shift_reg #(.DEPTH(16), .DATA_WIDTH(DW), .INIT(INIT16)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_addr(addr16), .i_data(data),
    .o_data(o16)
`ifdef SRLC_CASCADE_EN
    , .o_last(last16)
`endif
  );

  srlc_shift_reg #(.DEPTH(32), .DATA_WIDTH(DW), .INIT(INIT32)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_addr(addr32), .i_data(data),
    .o_data(o32)
`ifdef SRLC_CASCADE_EN
    , .o_last(last32)
`endif
  );

`ifdef SRLC_CASCADE_EN
  srlc_shift_reg #(.DEPTH(32), .DATA_WIDTH(DW), .INIT(32'h0)) casc0 (
    .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_addr(addr32), .i_data(data),
    .o_data(c0_data), .o_last(c0_last)
  );

  srlc_shift_reg #(.DEPTH(32), .DATA_WIDTH(DW), .INIT(32'h0)) casc1 (
    .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_addr(addr_c1), .i_data(c0_last),
    .o_data(c1_data), .o_last(c1_last)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stage a of a line whose power-up contents are init: the word written
  // a+1 enabled edges ago if that many writes happened since reset,
  // otherwise the init bit that has been pushed down to position a.
  function automatic logic [DW-1:0] exp_tap(input int a, input logic [63:0] init);
    if (a < wr_q.size()) return wr_q[a];
    return {DW{init[a - wr_q.size()]}};
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: let the edge act on the current inputs, then drive new ones
  // between edges and record what the outputs must show before the next edge.
  task automatic step(input bit r, input bit c, input int a16, input int a32,
                      input logic [DW-1:0] d);
    exp_t e;
    @(posedge clk);
    if (!rst && ce) begin
      wr_q.push_front(data);
      if (wr_q.size() > 64) void'(wr_q.pop_back());
    end
    #1;
    rst    = r;
    ce     = c;
    addr16 = 4'(a16);
    addr32 = 5'(a32);
    data   = d;
    if (r) wr_q.delete();
    e.d16 = exp_tap(a16, {48'h0, INIT16});
    e.d32 = exp_tap(a32, {32'h0, INIT32});
`ifdef SRLC_CASCADE_EN
    e.l16 = exp_tap(15, {48'h0, INIT16});
    e.l32 = exp_tap(31, {32'h0, INIT32});
    e.c0  = exp_tap(a32, 64'h0);
    e.c64 = exp_tap(63, 64'h0);
`endif
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are combinational and always presented; check mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("tap16", o16, e.d16);
      check("tap32", o32, e.d32);
`ifdef SRLC_CASCADE_EN
      check("last16", last16, e.l16);
      check("last32", last32, e.l32);
      check("casc0_tap", c0_data, e.c0);
      check("casc64_tap", c1_data, e.c64);
      check("casc64_last", c1_last, e.c64);
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst    = 1'b1;
    ce     = 1'b0;
    addr16 = '0;
    addr32 = '0;
    data   = '0;
`ifdef SRLC_CASCADE_EN
    addr_c1 = 5'd31;
`endif

    // Reset state across several taps.
    step(1, 0, 0, 0, 8'h00);
    step(1, 0, 15, 31, 8'h00);
    step(1, 1, 1, 7, 8'h3C);

    // 16-cycle delay of a single pulse at the deepest tap.
    step(0, 1, 15, 31, 8'hA5);
    for (int i = 0; i < 20; i++) step(0, 1, 15, 31, 8'h00);

    // Ramp with 32-stage tap at 4, then tap 0 without an intervening edge.
    for (int i = 0; i < 12; i++) step(0, 1, 15, 4, DW'(i));
    step(0, 1, 0, 0, 8'd12);
    step(0, 1, 0, 4, 8'd13);

    // Clock-enable hold with toggling data, then resume.
    for (int i = 0; i < 10; i++) step(0, 0, 3, 9, DW'($urandom));
    for (int i = 0; i < 8; i++) step(0, 1, 3, 9, DW'(8'h40 + i));

    // All ones, then async reset between edges; tap 0 / tap 1 / last.
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 8'hFF);
    step(1, 1, 0, 0, 8'hFF);
    step(1, 1, 1, 1, 8'hFF);
    step(1, 1, 15, 31, 8'hFF);
    // Release; the edge that sees reset still high must not shift.
    step(0, 1, 0, 0, 8'h5A);
    step(0, 1, 0, 0, 8'h00);
    step(0, 1, 1, 1, 8'h00);

    // Long single pulse for the chained 64-stage path.
    step(1, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h96);
    for (int i = 0; i < 70; i++) step(0, 1, 15, 31, 8'h00);

    // Randomised traffic including occasional mid-stream resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 80),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 31)), DW'($urandom));
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
